// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits them one bit per clock on registered outputs, with a one-word holding register.
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg, sreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             bit_out_reg, bit_out_next;
  logic             bit_valid_reg, bit_valid_next;
  logic             word_done_reg, word_done_next;
  logic             accept;

  // Bit that leaves the word first, and the word with that bit removed.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_ready = !pend_valid_reg;
  assign accept     = load_valid && load_ready;
  assign busy       = (state_reg == SHIFT) || pend_valid_reg;
  assign bit_out    = bit_out_reg;
  assign bit_valid  = bit_valid_reg;
  assign word_done  = word_done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      sreg_reg       <= '0;
      cnt_reg        <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      bit_out_reg    <= IDLE_BIT;
      bit_valid_reg  <= 1'b0;
      word_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sreg_reg       <= sreg_next;
      cnt_reg        <= cnt_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      bit_out_reg    <= bit_out_next;
      bit_valid_reg  <= bit_valid_next;
      word_done_reg  <= word_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sreg_next       = sreg_reg;
    cnt_next        = cnt_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    bit_out_next    = bit_out_reg;
    bit_valid_next  = bit_valid_reg;

    case (state_reg)
      IDLE: begin
        bit_valid_next = 1'b0;
        bit_out_next   = IDLE_BIT;
        if (accept) begin
          sreg_next      = drop_head(load_data);
          bit_out_next   = head_bit(load_data);
          bit_valid_next = 1'b1;
          cnt_next       = CNT_LAST;
          state_next     = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_reg != '0) begin
          bit_out_next = head_bit(sreg_reg);
          sreg_next    = drop_head(sreg_reg);
          cnt_next     = cnt_reg - 1'b1;
          if (accept) begin
            pend_next       = load_data;
            pend_valid_next = 1'b1;
          end
        end else if (pend_valid_reg) begin
          // Last bit is on the wire: the held word follows with no gap.
          sreg_next       = drop_head(pend_reg);
          bit_out_next    = head_bit(pend_reg);
          bit_valid_next  = 1'b1;
          cnt_next        = CNT_LAST;
          pend_valid_next = 1'b0;
        end else if (accept) begin
          sreg_next      = drop_head(load_data);
          bit_out_next   = head_bit(load_data);
          bit_valid_next = 1'b1;
          cnt_next       = CNT_LAST;
        end else begin
          bit_valid_next = 1'b0;
          bit_out_next   = IDLE_BIT;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next     = IDLE;
        bit_valid_next = 1'b0;
        bit_out_next   = IDLE_BIT;
        cnt_next       = '0;
      end
    endcase

    word_done_next = bit_valid_next && (cnt_next == '0);
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: two instances (MSB-first/idle 0, LSB-first/idle 1)
// share stimulus and are checked every cycle against a word-queue model.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;

  logic a_ready, a_bit, a_valid, a_done, a_busy;
  logic b_ready, b_bit, b_valid, b_done, b_busy;

  int n_vec = 0;
  int n_err = 0;

  // Model: words accepted but not yet fully sent, and bit index within the head word.
  logic [W-1:0] wq[$];
  int           pos = 0;

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(a_ready), .bit_out(a_bit), .bit_valid(a_valid),
    .word_done(a_done), .busy(a_busy)
  );

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(b_ready), .bit_out(b_bit), .bit_valid(b_valid),
    .word_done(b_done), .busy(b_busy)
  );

  // Downstream 1011 detector fed by the MSB-first stream.
  logic [3:0] det_sr;
  logic       det_out;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_sr  <= '0;
      det_out <= 1'b0;
    end else if (a_valid) begin
      det_sr  <= {det_sr[2:0], a_bit};
      det_out <= ({det_sr[2:0], a_bit} == 4'b1011);
    end else begin
      det_out <= 1'b0;
    end
  end

  function automatic logic word_bit(input logic [W-1:0] w, input int p, input bit msb);
    return msb ? w[W-1-p] : w[p];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (wq.size() > 0);
    chk("a_bit_valid", 32'(a_valid), 32'(ev));
    chk("a_bit_out", 32'(a_bit), 32'(ev ? word_bit(wq[0], pos, 1'b1) : 1'b0));
    chk("a_word_done", 32'(a_done), 32'(ev && pos == W - 1));
    chk("a_load_ready", 32'(a_ready), 32'(wq.size() < 2));
    chk("a_busy", 32'(a_busy), 32'(ev));
    chk("b_bit_valid", 32'(b_valid), 32'(ev));
    chk("b_bit_out", 32'(b_bit), 32'(ev ? word_bit(wq[0], pos, 1'b0) : 1'b1));
    chk("b_word_done", 32'(b_done), 32'(ev && pos == W - 1));
    chk("b_load_ready", 32'(b_ready), 32'(wq.size() < 2));
    chk("b_busy", 32'(b_busy), 32'(ev));
  endtask

  // One clock: present inputs, check outputs, advance the model across the edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    bit acc;
    load_valid = v;
    load_data  = d;
    check_outputs();
    acc = v && (wq.size() < 2);
    @(posedge clk);
    if (wq.size() > 0) begin
      pos++;
      if (pos == W) begin
        void'(wq.pop_front());
        pos = 0;
      end
    end
    if (acc) wq.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;
    @(negedge clk);

    // Single word 0xB0, with the 1011 detector firing one cycle after bit 4
    cycle(1'b1, 8'hB0);
    for (int k = 1; k <= W; k++) begin
      if (k == 4) chk("det1011_early", 32'(det_out), 32'd0);
      if (k == 5) chk("det1011_hit", 32'(det_out), 32'd1);
      cycle(1'b0, 8'($urandom));
    end
    repeat (3) cycle(1'b0, 8'($urandom));

    // Back-to-back, then a third word held against a full holding register
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h3C);
    repeat (20) cycle(1'b1, 8'($urandom));
    repeat (20) cycle(1'b0, 8'($urandom));

    // Asynchronous reset at bit 4 with the holding register full
    cycle(1'b1, 8'h5A);
    cycle(1'b1, 8'hC3);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    chk("pre_reset_busy", 32'(a_busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_a_bit_valid", 32'(a_valid), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_load_ready", 32'(a_ready), 32'd1);
    chk("rst_a_bit_out", 32'(a_bit), 32'd0);
    chk("rst_b_bit_out", 32'(b_bit), 32'd1);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    wq.delete();
    pos = 0;
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    cycle(1'b1, 8'h96);
    repeat (W + 2) cycle(1'b0, 8'($urandom));

    // Idle fill: no words offered
    repeat (24) cycle(1'b0, 8'($urandom));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 6, 8'($urandom));
    end
    repeat (2 * W + 2) cycle(1'b0, 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Parallel-to-serial front end for the bit-serial pattern detectors. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a registered serial output with a qualifying valid. The serial output drives the detector's single-bit `in` input directly. A one-entry holding register lets back-to-back words stream with no idle cycle between them.

## Interface
Parameters:
- `WIDTH`, default 8: word width; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, default 0: value driven on `bit_out` whenever `bit_valid` is 0.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `load_valid`  in  1  upstream word available.
- `load_data`  in  WIDTH  word to serialize; sampled only on an accepted handshake.
- `load_ready`  out  1  holding register empty; a word is accepted when `load_valid` and `load_ready` are both 1 at a rising edge.
- `bit_out`  out  1  registered serial data.
- `bit_valid`  out  1  registered; `bit_out` carries a real data bit.
- `word_done`  out  1  registered; 1-cycle pulse coincident with the last bit of each word.
- `busy`  out  1  1 while in SHIFT or while the holding register is full.

## Operation
- Storage: shift register `sreg` (WIDTH bits), remaining-bit counter `cnt` ($clog2(WIDTH) bits), holding register `pend` plus `pend_valid`.
- `load_ready` = !`pend_valid` (combinational).
- FSM has two states.
- IDLE:
  - On an accepted word, at that edge: load `sreg`, drive the first bit onto `bit_out`, set `bit_valid`=1, set `cnt`=WIDTH-1, and go to SHIFT. The word bypasses `pend`.
- SHIFT with `cnt`>0:
  - Each edge presents the next bit and decrements `cnt`.
  - An accepted word is written to `pend` and sets `pend_valid`.
- SHIFT with `cnt`==0 (last bit on the output, `word_done`=1), at the next edge:
  - If `pend_valid`: move `pend` into `sreg`, present its first bit, clear `pend_valid`, and stay in SHIFT.
  - Else, if a word is accepted this cycle: load it directly into `sreg` and stay in SHIFT.
  - Else: go to IDLE, with `bit_valid`=0 and `bit_out`=IDLE_BIT.
- Simultaneous events:
  - `pend` cannot be consumed and refilled at the same edge, because `load_ready` is 0 while `pend_valid`=1.
  - The refill happens one cycle later. This is still gapless, since WIDTH≥2.
- `word_done`=1 exactly when `bit_valid`=1 and `cnt`==0.
- `load_data` is ignored when no handshake occurs. `load_valid` may drop without an acceptance; no state change results.

## Timing
- Reset values: `bit_out`=IDLE_BIT, `bit_valid`=0, `word_done`=0, `busy`=0, `load_ready`=1, state IDLE, `pend_valid`=0, `cnt`=0.
- Reset is asynchronous. Asserting it mid-word aborts the current word and discards `pend` immediately, without waiting for a clock edge. The first edge after release sees IDLE.
- Latency: the first bit of an accepted word appears on `bit_out` in the cycle right after the accepting edge.
- Word occupancy: exactly WIDTH consecutive `bit_valid` cycles per word.
- Throughput: one word per WIDTH cycles with no gaps when upstream keeps `pend` filled.
- `bit_out`, `bit_valid` and `word_done` are flop outputs, so they can feed the detector's `in` without a combinational path.

## Test plan
- **Single word.** Reset, then accept 8'hB0 with MSB_FIRST=1.
  - Expect `bit_out` = 1,0,1,1,0,0,0,0 on cycles 1..8 after acceptance, with `bit_valid`=1 throughout and `word_done` only on cycle 8.
  - Then `bit_valid`=0 and `bit_out`=0.
  - A downstream 1011 detector's `out` must go high one cycle after the fourth bit.
- **Back-to-back.** Hold `load_valid`=1 with words 8'hA5 then 8'h3C.
  - Expect 16 contiguous `bit_valid` cycles carrying 10100101 00111100.
  - `load_ready` must drop the cycle after 8'h3C is accepted and rise again when it moves to `sreg`.
- **Backpressure.** Present a third word while `pend` is full.
  - `load_ready`=0 and the word is not accepted.
  - `load_data` changes while not ready must never appear on `bit_out`.
- **LSB order.** Set MSB_FIRST=0 and accept 8'hB0.
  - Expect `bit_out` = 0,0,0,0,1,1,0,1.
- **Reset mid-operation.** Pull `rst`=0 at bit 4 of a word with `pend` full.
  - Without waiting for an edge: `bit_valid`=0, `busy`=0, `load_ready`=1.
  - After release, the next accepted word streams from its first bit.
- **Idle fill.** Set IDLE_BIT=1 with no words offered.
  - `bit_out` holds 1 and `bit_valid` holds 0 indefinitely.
  - `word_done` never pulses.
